// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage ARM pipeline: shadow rd pipeline, load-use stall,
// branch flush, registered forwarding selects and NZVC flags. Define HAZ_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_unit #(
  parameter int NREGS    = 32,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int RW       = $clog2(NREGS),
  parameter int FW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [RW-1:0] id_ra,
  input  logic [RW-1:0] id_rb,
  input  logic          id_uses_ra,
  input  logic          id_uses_rb,
  input  logic [RW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_is_load,
  input  logic          ex_br_taken,
  input  logic          ex_flag_we,
  input  logic [3:0]    ex_flags,
  output logic          stall,
  output logic          flush,
  output logic [FW-1:0] fwd_a,
  output logic [FW-1:0] fwd_b,
`ifdef HAZ_PERF_CNT_EN
  output logic [3:0]    flags,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`else
  output logic [3:0]    flags
`endif
);

  localparam logic [RW-1:0] XZR = RW'(NREGS - 1);

  logic [DEPTH-1:0] sh_valid_q, sh_valid_d;
  logic [DEPTH-1:0] sh_load_q, sh_load_d;
  logic [RW-1:0]    sh_rd_q [DEPTH];

  logic [DEPTH-1:0] match_a, match_b, near_mask;
  logic             load_hit, stall_c, flush_c;
  logic [FW-1:0]    fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [3:0]       flags_q, flags_d;

  // Youngest match wins; a match in the last stage has retired by EX and reads the regfile.
  function automatic logic [FW-1:0] youngest_sel(input logic [DEPTH-1:0] m);
    youngest_sel = '0;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (m[i]) youngest_sel = FW'(i + 1);
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    match_a   = '0;
    match_b   = '0;
    near_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_a[i]   = sh_valid_q[i] && (sh_rd_q[i] == id_ra) && id_uses_ra && (id_ra != XZR);
      match_b[i]   = sh_valid_q[i] && (sh_rd_q[i] == id_rb) && id_uses_rb && (id_rb != XZR);
      near_mask[i] = (i < LOAD_LAT);
    end
  end

  assign load_hit = |((match_a | match_b) & sh_load_q & near_mask);
  assign flush_c  = ~reset & ex_br_taken;
  assign stall_c  = ~reset & id_valid & load_hit & ~ex_br_taken;

  always_comb begin
    sh_valid_d = {sh_valid_q[DEPTH-2:0], id_valid & id_regwrite & ~stall_c & ~flush_c};
    sh_load_d  = {sh_load_q[DEPTH-2:0], id_is_load};
    fwd_a_d    = (stall_c | flush_c) ? '0 : youngest_sel(match_a);
    fwd_b_d    = (stall_c | flush_c) ? '0 : youngest_sel(match_b);
    flags_d    = ex_flag_we ? ex_flags : flags_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_valid_q <= '0;
      fwd_a_q    <= '0;
      fwd_b_q    <= '0;
      flags_q    <= '0;
    end else begin
      sh_valid_q <= sh_valid_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      flags_q    <= flags_d;
    end
  end

  // NOTE: rd/is_load payload is qualified by sh_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    sh_load_q  <= sh_load_d;
    sh_rd_q[0] <= id_rd;
    for (int i = 1; i < DEPTH; i++) begin
      sh_rd_q[i] <= sh_rd_q[i-1];
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_c) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_c) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

  assign stall = stall_c;
  assign flush = flush_c;
  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed vector table, randomized run against a
// queue-based reference model, and a mid-run reset sequence.
module tb_pipe_hazard_unit;

  localparam int NREGS    = 32;
  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;

  typedef struct {
    logic       valid;
    logic [4:0] ra, rb;
    logic       ura, urb;
    logic [4:0] rd;
    logic       rw, ld, br, fwe;
    logic [3:0] fl;
  } in_t;

  typedef struct {
    in_t        in;
    logic       st, fls;
    logic [1:0] fa, fb;
    logic [3:0] flg;
  } vec_t;

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  logic       clk, reset;
  logic       id_valid, id_uses_ra, id_uses_rb, id_regwrite, id_is_load;
  logic [4:0] id_ra, id_rb, id_rd;
  logic       ex_br_taken, ex_flag_we;
  logic [3:0] ex_flags;
  logic       stall, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] flags;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipe_hazard_unit #(.NREGS(NREGS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .ex_br_taken(ex_br_taken), .ex_flag_we(ex_flag_we), .ex_flags(ex_flags),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZ_PERF_CNT_EN
    .flags(flags), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .flags(flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: shadow is a queue, index 0 = EX, oldest at the back.
  ent_t       sh[$];
  int         m_fa, m_fb, m_scnt, m_fcnt;
  logic [3:0] m_flags;

  function automatic bit hits(int r, bit use_r, int i);
    return use_r && (r != NREGS - 1) && sh[i].v && (sh[i].rd == r);
  endfunction

  function automatic bit m_stall(in_t x, bit rst);
    if (rst || !x.valid || x.br) return 1'b0;
    for (int i = 0; i < LOAD_LAT; i++)
      if (sh[i].ld && (hits(int'(x.ra), x.ura, i) || hits(int'(x.rb), x.urb, i))) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_sel(int r, bit use_r);
    for (int i = 0; i < DEPTH; i++)
      if (hits(r, use_r, i)) return (i + 1 <= DEPTH - 1) ? i + 1 : 0;
    return 0;
  endfunction

  task automatic m_clock(input in_t x, input bit rst);
    bit   st, fl;
    ent_t e;
    if (rst) begin
      sh.delete();
      e.v = 1'b0; e.rd = 0; e.ld = 1'b0;
      for (int i = 0; i < DEPTH; i++) sh.push_back(e);
      m_fa = 0; m_fb = 0; m_flags = 4'h0; m_scnt = 0; m_fcnt = 0;
      return;
    end
    st = m_stall(x, 1'b0);
    fl = x.br;
    m_fa = (st || fl) ? 0 : m_sel(int'(x.ra), x.ura);
    m_fb = (st || fl) ? 0 : m_sel(int'(x.rb), x.urb);
    m_scnt += int'(st);
    m_fcnt += int'(fl);
    if (x.fwe) m_flags = x.fl;
    e.v  = x.valid && x.rw && !st && !fl;
    e.rd = int'(x.rd);
    e.ld = x.ld;
    sh.push_front(e);
    void'(sh.pop_back());
  endtask

  task automatic drive(input in_t x, input bit rst);
    reset       = rst;
    id_valid    = x.valid;
    id_ra       = x.ra;
    id_rb       = x.rb;
    id_uses_ra  = x.ura;
    id_uses_rb  = x.urb;
    id_rd       = x.rd;
    id_regwrite = x.rw;
    id_is_load  = x.ld;
    ex_br_taken = x.br;
    ex_flag_we  = x.fwe;
    ex_flags    = x.fl;
  endtask

  function automatic in_t mk(bit v, int ra, int rb, bit ua, bit ub, int rd, bit rw, bit ld,
                             bit br, bit fwe, logic [3:0] fl);
    in_t x;
    x.valid = v;  x.ra = 5'(ra); x.rb = 5'(rb); x.ura = ua; x.urb = ub;
    x.rd = 5'(rd); x.rw = rw; x.ld = ld; x.br = br; x.fwe = fwe; x.fl = fl;
    return x;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t x, input bit st, input bit fls, input int fa, input int fb,
                     input logic [3:0] flg);
    vec_t v;
    v.in = x; v.st = st; v.fls = fls; v.fa = 2'(fa); v.fb = 2'(fb); v.flg = flg;
    tbl.push_back(v);
  endtask

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic in_t rnd_in();
    in_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.ra = rreg(); x.rb = rreg(); x.rd = rreg();
    x.ura = 1'($urandom_range(0, 1)); x.urb = 1'($urandom_range(0, 1));
    x.rw  = ($urandom_range(0, 3) != 0);
    x.ld  = ($urandom_range(0, 2) == 0);
    x.br  = ($urandom_range(0, 9) == 0);
    x.fwe = ($urandom_range(0, 3) == 0);
    x.fl  = 4'($urandom_range(0, 15));
    return x;
  endfunction

  initial begin
    in_t nop, x;
    bit  rst;

    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    drive(nop, 1'b1);
    m_clock(nop, 1'b1);

    // Directed table: expectations are what is observed in the cycle the row is applied.
    add(mk(1, 5, 0, 0, 0, 1, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // ADD X1
    add(mk(1, 1, 6, 1, 1, 7, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // SUB reads X1
    add(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 4'h0), 0, 0, 1, 0, 4'h0);   // SUB in EX: fwd_a=1
    add(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);
    add(mk(1, 9, 2, 1, 1, 0, 0, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // consumer rb=2, gap 1
    add(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 4'h0), 0, 0, 0, 2, 4'h0);
    add(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);
    add(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);
    add(mk(1, 0, 4, 0, 1, 0, 0, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // consumer rb=4, gap 2
    add(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // LDUR X3
    add(mk(1, 3, 0, 1, 0, 12, 1, 0, 0, 0, 4'h0), 1, 0, 0, 0, 4'h0);  // load-use stall
    add(mk(1, 3, 0, 1, 0, 12, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);  // held ADD proceeds
    add(mk(1, 0, 0, 0, 0, 31, 1, 0, 0, 0, 4'h0), 0, 0, 2, 0, 4'h0);  // XZR producer
    add(mk(1, 31, 31, 1, 1, 0, 0, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);
    add(mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);   // LDUR X5
    add(mk(1, 5, 0, 1, 0, 13, 1, 0, 1, 0, 4'h0), 0, 1, 0, 0, 4'h0);  // flush beats stall
    add(mk(1, 13, 5, 1, 1, 0, 0, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'h0);  // rd13 must be absent
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0100), 0, 0, 0, 2, 4'h0);
    for (int i = 0; i < 5; i++)
      add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF), 0, 0, 0, 0, 4'b0100);
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1010), 0, 1, 0, 0, 4'b0100);
    add(nop, 0, 0, 0, 0, 4'b1010);
    add(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'b1010);
    add(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'b1010);
    add(mk(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 4'h0), 0, 0, 0, 0, 4'b1010);
    add(nop, 0, 0, 1, 0, 4'b1010);                                      // younger X6 wins

    repeat (2) begin
      @(negedge clk); drive(nop, 1'b1); m_clock(nop, 1'b1);
    end

    foreach (tbl[k]) begin
      @(negedge clk); drive(tbl[k].in, 1'b0); #1;
      check($sformatf("tbl%0d_stall", k), 32'(stall), 32'(tbl[k].st));
      check($sformatf("tbl%0d_flush", k), 32'(flush), 32'(tbl[k].fls));
      check($sformatf("tbl%0d_fwd_a", k), 32'(fwd_a), 32'(tbl[k].fa));
      check($sformatf("tbl%0d_fwd_b", k), 32'(fwd_b), 32'(tbl[k].fb));
      check($sformatf("tbl%0d_flags", k), 32'(flags), 32'(tbl[k].flg));
      m_clock(tbl[k].in, 1'b0);
    end

`ifdef HAZ_PERF_CNT_EN
    @(negedge clk); drive(nop, 1'b0); #1;
    check("tbl_stall_cnt", stall_cnt, 32'd1);
    check("tbl_flush_cnt", flush_cnt, 32'd2);
    m_clock(nop, 1'b0);
`endif

    // Randomized run; a stalled ID instruction is held like a real pipeline would.
    x = rnd_in();
    for (int c = 0; c < 800; c++) begin
      bit exp_st;
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk); drive(x, rst); #1;
      exp_st = m_stall(x, rst);
      check($sformatf("rnd%0d_stall", c), 32'(stall), 32'(exp_st));
      check($sformatf("rnd%0d_flush", c), 32'(flush), 32'(!rst && x.br));
      check($sformatf("rnd%0d_fwd_a", c), 32'(fwd_a), 32'(m_fa));
      check($sformatf("rnd%0d_fwd_b", c), 32'(fwd_b), 32'(m_fb));
      check($sformatf("rnd%0d_flags", c), 32'(flags), 32'(m_flags));
`ifdef HAZ_PERF_CNT_EN
      check($sformatf("rnd%0d_stall_cnt", c), stall_cnt, 32'(m_scnt));
      check($sformatf("rnd%0d_flush_cnt", c), flush_cnt, 32'(m_fcnt));
`endif
      m_clock(x, rst);
      if (exp_st) begin
        x.br = ($urandom_range(0, 9) == 0); x.fwe = 1'($urandom_range(0, 1));
        x.fl = 4'($urandom_range(0, 15));
      end else begin
        x = rnd_in();
      end
    end

    // Mid-run reset: load X3 in flight with flags set, then reset while ADD X3 waits in ID.
    @(negedge clk); drive(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 4'hF), 1'b0); #1;
    m_clock(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 1, 4'hF), 1'b0);
    @(negedge clk); drive(mk(1, 3, 0, 1, 0, 12, 1, 0, 0, 0, 4'h0), 1'b1); #1;
    check("rst_flags_before", 32'(flags), 32'hF);
    check("rst_stall_during", 32'(stall), 32'd0);
    @(negedge clk); drive(mk(1, 3, 0, 1, 0, 12, 1, 0, 0, 0, 4'h0), 1'b0); #1;
    check("rst_stall_after", 32'(stall), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif
    @(negedge clk); drive(nop, 1'b0); #1;
    check("rst_shadow_cleared", 32'(fwd_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
